// File: rtl/fc_input_flattener.sv
// Gathers a serial feature stream into a flattened vector, starts the FC layer,
// and captures its result on the rising edge of the result-valid window.
module fc_input_flattener #(
    parameter int DATA_W  = 22,
    parameter int DEPTH   = 225,
    parameter int RES_W   = 48,
    parameter int TIMEOUT = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_valid,
    input  logic signed [DATA_W-1:0] i_data,
    input  logic                     i_last,
    output logic                     o_ready,
    output logic signed [DATA_W-1:0] o_flattened_data [0:DEPTH-1],
    output logic                     o_start,
    input  logic                     i_result_valid,
    input  logic signed [RES_W-1:0]  i_result_data,
    output logic signed [RES_W-1:0]  o_result,
    output logic                     o_result_strobe,
    output logic                     o_frame_err,
    output logic                     o_timeout,
    output logic                     o_busy
);

    localparam int CNT_W = $clog2(DEPTH);
    localparam int TMO_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {FILL, START, WAIT_RESULT, RELEASE} state_t;

    state_t           state;
    logic [CNT_W-1:0] wr_cnt;
    logic [TMO_W-1:0] tmo_cnt;
    logic [TMO_W-1:0] tmo_cnt_inc;
    logic             rv_prev;
    logic             rv_rise;

    assign o_ready     = (state == FILL);
    assign o_busy      = (state != FILL);
    assign tmo_cnt_inc = tmo_cnt + 1'b1;
    assign rv_rise     = i_result_valid && !rv_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= FILL;
            wr_cnt          <= '0;
            tmo_cnt         <= '0;
            rv_prev         <= 1'b0;
            o_result        <= '0;
            o_start         <= 1'b0;
            o_result_strobe <= 1'b0;
            o_frame_err     <= 1'b0;
            o_timeout       <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                o_flattened_data[i] <= '0;
            end
        end else begin
            rv_prev         <= i_result_valid;
            o_start         <= 1'b0;
            o_result_strobe <= 1'b0;
            o_frame_err     <= 1'b0;
            o_timeout       <= 1'b0;
            case (state)
                FILL: begin
                    if (i_valid) begin
                        if (wr_cnt == LAST_IDX && i_last) begin
                            o_flattened_data[wr_cnt] <= i_data;
                            wr_cnt  <= '0;
                            o_start <= 1'b1;
                            state   <= START;
                        end else if (wr_cnt == LAST_IDX || i_last) begin
                            // Length mismatch: drop the offending element and restart at index 0.
                            o_frame_err <= 1'b1;
                            wr_cnt      <= '0;
                        end else begin
                            o_flattened_data[wr_cnt] <= i_data;
                            wr_cnt <= wr_cnt + 1'b1;
                        end
                    end
                end
                START: begin
                    tmo_cnt <= '0;
                    state   <= WAIT_RESULT;
                end
                WAIT_RESULT: begin
                    // Abort is decided on the incremented count so the pulse lands TIMEOUT cycles after start.
                    if (rv_rise) begin
                        o_result        <= i_result_data;
                        o_result_strobe <= 1'b1;
                        state           <= RELEASE;
                    end else if (tmo_cnt_inc == TMO_LAST) begin
                        o_timeout <= 1'b1;
                        state     <= FILL;
                    end else begin
                        tmo_cnt <= tmo_cnt_inc;
                    end
                end
                RELEASE: begin
                    if (!i_result_valid) state <= FILL;
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_fc_input_flattener.sv
// Directed bench for fc_input_flattener: one instance with the default timeout,
// one with TIMEOUT=64; a select line routes stimulus and observation to one of them.
module tb_fc_input_flattener;
    localparam int DW = 22;
    localparam int D  = 225;
    localparam int RW = 48;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic                 sel   = 1'b0;
    logic                 valid = 1'b0;
    logic signed [DW-1:0] data  = '0;
    logic                 last  = 1'b0;
    logic                 rv    = 1'b0;
    logic signed [RW-1:0] rdata = '0;

    logic                 rdy0, st0, stb0, fe0, to0, busy0;
    logic                 rdy1, st1, stb1, fe1, to1, busy1;
    logic signed [RW-1:0] res0, res1;
    logic signed [DW-1:0] f0 [0:D-1];
    logic signed [DW-1:0] f1 [0:D-1];

    logic                 ready, start, strobe, ferr, tmo, busy;
    logic signed [RW-1:0] result;
    logic signed [DW-1:0] flat [0:D-1];

    fc_input_flattener #(.DATA_W(DW), .DEPTH(D), .RES_W(RW), .TIMEOUT(1024)) dut (
        .clk(clk), .rst(rst), .i_valid(valid & ~sel), .i_data(data), .i_last(last),
        .o_ready(rdy0), .o_flattened_data(f0), .o_start(st0),
        .i_result_valid(rv & ~sel), .i_result_data(rdata), .o_result(res0),
        .o_result_strobe(stb0), .o_frame_err(fe0), .o_timeout(to0), .o_busy(busy0));

    fc_input_flattener #(.DATA_W(DW), .DEPTH(D), .RES_W(RW), .TIMEOUT(64)) dut_to (
        .clk(clk), .rst(rst), .i_valid(valid & sel), .i_data(data), .i_last(last),
        .o_ready(rdy1), .o_flattened_data(f1), .o_start(st1),
        .i_result_valid(rv & sel), .i_result_data(rdata), .o_result(res1),
        .o_result_strobe(stb1), .o_frame_err(fe1), .o_timeout(to1), .o_busy(busy1));

    assign ready  = sel ? rdy1  : rdy0;
    assign start  = sel ? st1   : st0;
    assign strobe = sel ? stb1  : stb0;
    assign ferr   = sel ? fe1   : fe0;
    assign tmo    = sel ? to1   : to0;
    assign busy   = sel ? busy1 : busy0;
    assign result = sel ? res1  : res0;
    always_comb begin
        for (int i = 0; i < D; i++) flat[i] = sel ? f1[i] : f0[i];
    end

    int tests = 0;
    int fails = 0;
    int start_cnt = 0;
    int stb_cnt = 0;
    logic signed [DW-1:0] vec [0:D-1];
    logic signed [RW-1:0] exp_r;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (start)  start_cnt++;
        if (strobe) stb_cnt++;
    endtask

    task automatic check_vec(input string tag);
        int bad = 0;
        for (int k = 0; k < D; k++) if (flat[k] !== vec[k]) bad++;
        check(tag, bad, 0);
    endtask

    // Streams vec[0..n-1]; i_last on index last_at; valid duty in percent.
    task automatic send(input int n, input int last_at, input int duty);
        for (int k = 0; k < n; k++) begin
            while ($urandom_range(0, 99) >= duty) begin
                valid = 1'b0;
                tick();
            end
            valid = 1'b1;
            data  = vec[k];
            last  = (k == last_at);
            for (int g = 0; g < 50 && !ready; g++) tick();
            if (!ready) check("ready_wait", 0, 1);
            tick();
        end
        valid = 1'b0;
        last  = 1'b0;
    endtask

    // FC stub: result-valid rises lat cycles after the o_start cycle and stays for win cycles.
    task automatic fc_respond(input string tag, input int lat, input int win,
                              input logic signed [RW-1:0] val);
        for (int i = 0; i < lat - 1; i++) tick();
        rv = 1'b1;
        rdata = val;
        tick();
        check({tag, "_strobe"}, strobe, 1);
        check({tag, "_result"}, result, val);
        for (int i = 0; i < win - 1; i++) tick();
        check({tag, "_hold_ready"}, ready, 0);
        rv = 1'b0;
        tick();
        check({tag, "_ready_back"}, ready, 1);
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        for (int k = 0; k < D; k++) vec[k] = '0;
        check("rst_ready", ready, 1);
        check("rst_busy", busy, 0);
        check("rst_start", start, 0);
        check("rst_result", result, 0);
        check("rst_flags", {strobe, ferr, tmo}, 0);
        check_vec("rst_vec");

        // Nominal frame, no gaps, FC answers 235 cycles after start for 17 cycles.
        for (int k = 0; k < D; k++) vec[k] = DW'(k);
        start_cnt = 0;
        stb_cnt = 0;
        send(D, D - 1, 100);
        check("nom_start", start, 1);
        check("nom_ready_low", ready, 0);
        check("nom_busy", busy, 1);
        for (int i = 0; i < 234; i++) tick();
        check_vec("nom_vec_wait");
        rv = 1'b1;
        rdata = 48'sh0000_1234_5678;
        tick();
        check("nom_strobe", strobe, 1);
        check("nom_result", result, 48'h0000_1234_5678);
        for (int i = 0; i < 16; i++) tick();
        check_vec("nom_vec_window");
        check("nom_release_ready", ready, 0);
        rv = 1'b0;
        tick();
        check("nom_ready_back", ready, 1);
        check("nom_busy_back", busy, 0);
        check("nom_start_cnt", start_cnt, 1);
        check("nom_stb_cnt", stb_cnt, 1);

        // Gappy stream with negative values; stray valids while busy must be ignored.
        for (int k = 0; k < D; k++)
            vec[k] = (k % 3 == 0) ? -22'sd1 : (k % 3 == 1) ? -22'sd2097152 : DW'(k - 112);
        send(D, D - 1, 30);
        check("bp_start", start, 1);
        valid = 1'b1;
        data  = 22'sh1555;
        last  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ready) check("bp_ready_busy", ready, 0);
        end
        exp_r = -48'sd5;
        rv = 1'b1;
        rdata = exp_r;
        tick();
        check("bp_result", result, exp_r);
        valid = 1'b0;
        last  = 1'b0;
        check_vec("bp_vec");
        rv = 1'b0;
        tick();
        check("bp_ready_back", ready, 1);

        // Short frame, then a good frame of 500+k.
        for (int k = 0; k < D; k++) vec[k] = DW'(1000 + k);
        start_cnt = 0;
        send(101, 100, 100);
        check("short_ferr", ferr, 1);
        check("short_no_start", start, 0);
        check("short_busy", busy, 0);
        tick();
        check("short_ferr_pulse", ferr, 0);
        for (int k = 0; k < D; k++) vec[k] = DW'(500 + k);
        send(D, D - 1, 100);
        check("short_next_start", start, 1);
        check_vec("short_next_vec");
        fc_respond("short_next", 5, 3, 48'sh0000_0000_0777);
        check("short_start_cnt", start_cnt, 1);

        // Long frame: 225 elements with no i_last.
        start_cnt = 0;
        send(D, -1, 100);
        check("long_ferr", ferr, 1);
        check("long_busy", busy, 0);
        tick();
        tick();
        check("long_start_cnt", start_cnt, 0);

        // Reset after 150 elements of a frame.
        for (int k = 0; k < D; k++) vec[k] = DW'(7777);
        send(150, -1, 100);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < D; k++) vec[k] = '0;
        check_vec("mrst_vec");
        check("mrst_result", result, 0);
        check("mrst_ready", ready, 1);
        for (int k = 0; k < D; k++) vec[k] = DW'(3 * k - 300);
        send(D, D - 1, 100);
        check("mrst_start", start, 1);
        check_vec("mrst_frame_vec");
        fc_respond("mrst", 8, 2, -48'sd123456789);

        // TIMEOUT=64 instance: capture once, then no response, then stale valid.
        sel = 1'b1;
        for (int k = 0; k < D; k++) vec[k] = DW'(k * 5);
        send(D, D - 1, 100);
        check("to_first_start", start, 1);
        fc_respond("to_first", 10, 2, 48'sh7FFF_0000_0001);
        stb_cnt = 0;
        send(D, D - 1, 100);
        check("to_start", start, 1);
        begin
            int n = 0;
            while (!tmo && n < 200) begin
                tick();
                n++;
            end
            check("to_cycles", n, 64);
        end
        check("to_pulse", tmo, 1);
        check("to_result_kept", result, 48'h7FFF_0000_0001);
        check("to_ready", ready, 1);
        check("to_no_strobe", stb_cnt, 0);
        tick();
        check("to_pulse_end", tmo, 0);

        rv = 1'b1;
        rdata = 48'sh0000_0000_0111;
        tick();
        send(D, D - 1, 100);
        check("stale_start", start, 1);
        for (int i = 0; i < 20; i++) tick();
        check("stale_no_strobe", stb_cnt, 0);
        check("stale_result_kept", result, 48'h7FFF_0000_0001);
        rv = 1'b0;
        tick();
        fc_respond("stale_fresh", 1, 2, 48'sh0000_00AB_CDEF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
